ps2_mouse_packetizer: RTL

Host-side stage between the PS/2 transceiver and the pointer logic. After reset it issues the Enable Data Reporting command (0xF4) through the transceiver's transmit port and waits for the mouse acknowledge (0xFA). It then assembles the received byte stream into 3-byte standard mouse packets. Each packet is presented as button bits plus signed 9-bit X/Y deltas, with a one-cycle valid strobe.

---
 rtl/ps2_mouse_packetizer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_packetizer.sv
// PS/2 mouse host packetizer: enables data reporting, then assembles 3-byte packets.
module ps2_mouse_packetizer #(
  parameter int unsigned ACK_TIMEOUT = 2500000,
  parameter int unsigned BYTE_GAP    = 100000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_write,
  output logic       streaming,
  output logic       fail,
  output logic       pkt_valid,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_mid,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       x_ovf,
  output logic       y_ovf
);

  localparam int unsigned TimerMax = (ACK_TIMEOUT > BYTE_GAP) ? ACK_TIMEOUT : BYTE_GAP;
  localparam int unsigned TimerW   = $clog2(TimerMax) + 1;
  localparam int unsigned RetryW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TimerW-1:0] AckLim   = TimerW'(ACK_TIMEOUT);
  localparam logic [TimerW-1:0] GapLim   = TimerW'(BYTE_GAP);
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);

  typedef enum logic [2:0] {
    StSend,
    StWaitTx,
    StWaitAck,
    StFailed,
    StStream
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d, timer_inc;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [1:0]          idx_q, idx_d;
  // Header byte without the sync bit: {b7, b6, b5, b4, b2, b1, b0}.
  logic [6:0]          hdr_q, hdr_d;
  logic [7:0]          xb_q, xb_d;
  logic                tx_write_q, tx_write_d;
  logic                streaming_q, streaming_d;
  logic                fail_q, fail_d;
  logic                pkt_valid_q, pkt_valid_d;
  logic [2:0]          btn_q, btn_d;
  logic [8:0]          dx_q, dx_d;
  logic [8:0]          dy_q, dy_d;
  logic [1:0]          ovf_q, ovf_d;

  // Saturating increment shared by the ack timeout and the inter-byte gap timer.
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TimerW'(1);

  // Next-state logic for the enable handshake and the packet assembler.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    idx_d       = idx_q;
    hdr_d       = hdr_q;
    xb_d        = xb_q;
    tx_write_d  = 1'b0;
    streaming_d = streaming_q;
    fail_d      = fail_q;
    pkt_valid_d = 1'b0;
    btn_d       = btn_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      StSend: begin
        tx_write_d = 1'b1;
        state_d    = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          timer_d = '0;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        timer_d = timer_inc;
        // A received byte wins over a simultaneous timeout.
        if (rx_done && (rx_data == 8'hFA)) begin
          streaming_d = 1'b1;
          timer_d     = '0;
          state_d     = StStream;
        end else if (rx_done || (timer_q >= AckLim)) begin
          retry_d = retry_q + RetryW'(1);
          if (retry_d < MaxRetry) begin
            state_d = StSend;
          end else begin
            fail_d  = 1'b1;
            state_d = StFailed;
          end
        end
      end
      StFailed: begin
        state_d = StFailed;
      end
      StStream: begin
        if (rx_done) begin
          timer_d = '0;
          unique case (idx_q)
            2'd0: begin
              if (rx_data[3]) begin
                hdr_d = {rx_data[7:4], rx_data[2:0]};
                idx_d = 2'd1;
              end
            end
            2'd1: begin
              xb_d  = rx_data;
              idx_d = 2'd2;
            end
            default: begin
              btn_d       = hdr_q[2:0];
              dx_d        = {hdr_q[3], xb_q};
              dy_d        = {hdr_q[4], rx_data};
              ovf_d       = {hdr_q[6], hdr_q[5]};
              pkt_valid_d = 1'b1;
              idx_d       = 2'd0;
            end
          endcase
        end else if (idx_q != 2'd0) begin
          timer_d = timer_inc;
          if (timer_q >= GapLim) begin
            idx_d = 2'd0;
          end
        end
      end
      default: begin
        state_d = StSend;
      end
    endcase
  end

  // State and registered outputs with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StSend;
      timer_q     <= '0;
      retry_q     <= '0;
      idx_q       <= 2'd0;
      hdr_q       <= '0;
      xb_q        <= '0;
      tx_write_q  <= 1'b0;
      streaming_q <= 1'b0;
      fail_q      <= 1'b0;
      pkt_valid_q <= 1'b0;
      btn_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      idx_q       <= idx_d;
      hdr_q       <= hdr_d;
      xb_q        <= xb_d;
      tx_write_q  <= tx_write_d;
      streaming_q <= streaming_d;
      fail_q      <= fail_d;
      pkt_valid_q <= pkt_valid_d;
      btn_q       <= btn_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign tx_data   = 8'hF4;
  assign tx_write  = tx_write_q;
  assign streaming = streaming_q;
  assign fail      = fail_q;
  assign pkt_valid = pkt_valid_q;
  assign btn_left  = btn_q[0];
  assign btn_right = btn_q[1];
  assign btn_mid   = btn_q[2];
  assign dx        = dx_q;
  assign dy        = dy_q;
  assign x_ovf     = ovf_q[0];
  assign y_ovf     = ovf_q[1];

endmodule
